serial_parity_transmitter: RTL

Asynchronous-serial (UART-style) frame transmitter with even parity. Accepts a parallel data word over a valid/ready handshake, computes the even-parity bit over the word, and shifts out start, data (LSB first), parity and stop bits at a fixed bit period. It consumes the parity function produced by the even-parity generator stage and drives the line toward the serial pin or a downstream line driver.

---
 rtl/serial_parity_transmitter_if.sv | 27 ++
 rtl/serial_parity_transmitter.sv | 123 ++++++++++++
 2 files changed

// File: rtl/serial_parity_transmitter_if.sv
// Word handshake and serial line bundle for the parity transmitter.
// Master supplies words; slave is the transmitter.
interface serial_parity_transmitter_if #(
  parameter int width = 8
);
  logic [width-1:0] i_data;
  logic             i_valid;
  logic             o_ready;
  logic             o_tx;
  logic             o_busy;

  modport master (
    output i_data,
    output i_valid,
    input  o_ready,
    input  o_tx,
    input  o_busy
  );

  modport slave (
    input  i_data,
    input  i_valid,
    output o_ready,
    output o_tx,
    output o_busy
  );
endinterface

// File: rtl/serial_parity_transmitter.sv
// UART-style frame transmitter: start, data LSB first, even parity, stop.
// Line level is registered so o_tx never glitches.
module serial_parity_transmitter #(
  parameter int width          = 8,
  parameter int clocks_per_bit = 16,
  parameter int stop_bits      = 1
) (
  input logic clk,
  input logic rst,
  serial_parity_transmitter_if.slave bus
);

  localparam int CW = (clocks_per_bit > 1) ?
                      $clog2(clocks_per_bit) : 1;
  localparam int BW = $clog2(width + 1);

  localparam logic [CW-1:0] CYC_LAST  = CW'(clocks_per_bit - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(width - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(stop_bits - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t           state;
  logic [CW-1:0]    cyc;
  logic [BW-1:0]    bitn;
  logic [width-1:0] shreg;
  logic [width-1:0] shnext;
  logic             par;
  logic             tx;
  logic             bit_end;

  assign bit_end = (cyc == CYC_LAST);
  assign shnext  = shreg >> 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cyc   <= '0;
      bitn  <= '0;
      shreg <= '0;
      par   <= 1'b0;
      tx    <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          tx <= 1'b1;
          if (bus.i_valid) begin
            shreg <= bus.i_data;
            par   <= ^bus.i_data;
            cyc   <= '0;
            bitn  <= '0;
            state <= START;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            cyc   <= '0;
            state <= DATA;
            tx    <= shreg[0];
          end else begin
            cyc <= cyc + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cyc <= '0;
            if (bitn == BIT_LAST) begin
              state <= PARITY;
              tx    <= par;
            end else begin
              bitn  <= bitn + BW'(1);
              shreg <= shnext;
              tx    <= shnext[0];
            end
          end else begin
            cyc <= cyc + CW'(1);
          end
        end
        PARITY: begin
          if (bit_end) begin
            cyc   <= '0;
            bitn  <= '0;
            state <= STOP;
            tx    <= 1'b1;
          end else begin
            cyc <= cyc + CW'(1);
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (bit_end) begin
            cyc <= '0;
            // bit counter is reused to count stop bits
            if (bitn == STOP_LAST) begin
              bitn  <= '0;
              state <= IDLE;
            end else begin
              bitn <= bitn + BW'(1);
            end
          end else begin
            cyc <= cyc + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

  assign bus.o_ready = (state == IDLE);
  assign bus.o_busy  = (state != IDLE);
  assign bus.o_tx    = tx;

endmodule
